mem_bist_master: RTL and testbench

- Memory-bus initiator: the CPU-side end of the mem_read/mem_write/mem_ack handshake that io_ctrl answers.
- Runs a self-contained write-then-readback test over a word range through io_ctrl/SRAM, then reports pass/fail, error count and first failing address.
- Sits beside cpu; the top-level muxes its mem_* outputs onto io_ctrl while the test runs.

---
 rtl/mem_bist_master.sv | 226 ++++++++++++++++++++++
 tb/tb_mem_bist_master.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bist_master.sv
// mem_bist_master
//   Memory-bus initiator that runs a write-then-readback self test over a
//   word range. It uses the four-phase mem_read/mem_write/mem_ack handshake
//   that io_ctrl answers. Each word is written with data = seed ^ addr. The
//   range is then read back and compared. When the test ends, the block
//   reports pass/fail, the mismatch count and the first failing address.
//
//   Optional build macro: MEM_BIST_TIMEOUT_EN
//     When it is defined, every REQ/REL state has an ack-wait limit of
//     TIMEOUT_CYC cycles. If the limit expires, timeout is set and the test
//     aborts into DONE with pass=0. When it is not defined, the block waits
//     indefinitely and timeout is tied to 0.
//
// Ports
//   clk, reset        clock; asynchronous active-low reset
//   start             one-cycle pulse, accepted only in IDLE or DONE
//   base_addr         first word address (latched on start)
//   word_count        number of words to test (latched on start)
//   seed              pattern seed (latched on start)
//   busy, done, pass  status; pass is valid while done=1
//   err_count         readback mismatches, saturating
//   first_err_addr    address of the first mismatch, 0 if there is none
//   timeout           sticky ack-timeout flag
//   mem_read/mem_write/mem_addr/mem_write_data  request side of the bus
//   mem_ack/mem_read_data                        responder side of the bus
module mem_bist_master #(
   parameter int unsigned ADDR_STEP   = 1,
   parameter int unsigned CNT_W       = 16,
   parameter int unsigned TIMEOUT_CYC = 1024
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [31:0]      base_addr,
   input  logic [CNT_W-1:0] word_count,
   input  logic [31:0]      seed,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [CNT_W-1:0] err_count,
   output logic [31:0]      first_err_addr,
   output logic             timeout,
   output logic             mem_read,
   output logic             mem_write,
   input  logic             mem_ack,
   output logic [31:0]      mem_addr,
   input  logic [31:0]      mem_read_data,
   output logic [31:0]      mem_write_data
);

   typedef enum logic [2:0] {
      S_IDLE, S_WR_REQ, S_WR_REL, S_RD_REQ, S_RD_REL, S_DONE
   } state_t;

   state_t           state_reg;
   logic [31:0]      base_reg;
   logic [31:0]      seed_reg;
   logic [CNT_W-1:0] count_reg;
   logic [CNT_W-1:0] idx_reg;
   logic             last_word;
   logic [31:0]      addr_next;

   // count_reg is never 0 outside IDLE/DONE, so count_reg-1 cannot wrap here.
   // This also makes an all-ones count safe: idx stops one short of overflow.
   assign last_word = (idx_reg == count_reg - CNT_W'(1));
   assign addr_next = mem_addr + 32'(ADDR_STEP);

`ifdef MEM_BIST_TIMEOUT_EN
   localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
   logic [TMO_W-1:0] tmo_cnt_reg;
   logic             timeout_reg;
   logic             waiting;

   // High while a handshake state has not yet seen the ack level it waits for.
   always_comb begin
      waiting = 1'b0;
      case (state_reg)
         S_WR_REQ, S_RD_REQ: waiting = !mem_ack;
         S_WR_REL, S_RD_REL: waiting = mem_ack;
         default:            waiting = 1'b0;
      endcase
   end

   assign timeout = timeout_reg;
`else
   assign timeout = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg      <= S_IDLE;
         base_reg       <= '0;
         seed_reg       <= '0;
         count_reg      <= '0;
         idx_reg        <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
         pass           <= 1'b0;
         err_count      <= '0;
         first_err_addr <= '0;
         mem_read       <= 1'b0;
         mem_write      <= 1'b0;
         mem_addr       <= '0;
         mem_write_data <= '0;
`ifdef MEM_BIST_TIMEOUT_EN
         tmo_cnt_reg    <= '0;
         timeout_reg    <= 1'b0;
`endif
      end else begin
         case (state_reg)
            S_IDLE, S_DONE: begin
               if (start) begin
                  base_reg       <= base_addr;
                  seed_reg       <= seed;
                  count_reg      <= word_count;
                  idx_reg        <= '0;
                  err_count      <= '0;
                  first_err_addr <= '0;
`ifdef MEM_BIST_TIMEOUT_EN
                  timeout_reg    <= 1'b0;
`endif
                  if (word_count == '0) begin
                     // An empty range passes immediately and does not touch the bus.
                     state_reg <= S_DONE;
                     done      <= 1'b1;
                     pass      <= 1'b1;
                     busy      <= 1'b0;
                  end else begin
                     state_reg      <= S_WR_REQ;
                     done           <= 1'b0;
                     pass           <= 1'b0;
                     busy           <= 1'b1;
                     mem_write      <= 1'b1;
                     mem_addr       <= base_addr;
                     mem_write_data <= seed ^ base_addr;
                  end
               end
            end

            S_WR_REQ: begin
               if (mem_ack) begin
                  mem_write <= 1'b0;
                  state_reg <= S_WR_REL;
               end
            end

            S_WR_REL: begin
               if (!mem_ack) begin
                  if (last_word) begin
                     // Restart at the base address for the readback pass.
                     idx_reg   <= '0;
                     mem_addr  <= base_reg;
                     mem_read  <= 1'b1;
                     state_reg <= S_RD_REQ;
                  end else begin
                     idx_reg        <= idx_reg + CNT_W'(1);
                     mem_addr       <= addr_next;
                     mem_write_data <= seed_reg ^ addr_next;
                     mem_write      <= 1'b1;
                     state_reg      <= S_WR_REQ;
                  end
               end
            end

            S_RD_REQ: begin
               if (mem_ack) begin
                  if (mem_read_data != (seed_reg ^ mem_addr)) begin
                     // Saturation keeps err_count from returning to zero, so
                     // a zero count reliably marks the first error.
                     if (err_count == '0)
                        first_err_addr <= mem_addr;
                     if (err_count != '1)
                        err_count <= err_count + CNT_W'(1);
                  end
                  mem_read  <= 1'b0;
                  state_reg <= S_RD_REL;
               end
            end

            S_RD_REL: begin
               if (!mem_ack) begin
                  if (last_word) begin
                     state_reg <= S_DONE;
                     busy      <= 1'b0;
                     done      <= 1'b1;
                     pass      <= (err_count == '0);
                  end else begin
                     idx_reg   <= idx_reg + CNT_W'(1);
                     mem_addr  <= addr_next;
                     mem_read  <= 1'b1;
                     state_reg <= S_RD_REQ;
                  end
               end
            end

            default: begin
               state_reg <= S_IDLE;
               mem_read  <= 1'b0;
               mem_write <= 1'b0;
               busy      <= 1'b0;
            end
         endcase

`ifdef MEM_BIST_TIMEOUT_EN
         // Every state change happens on a matched ack level, so clearing the
         // counter whenever nothing is pending reloads it on state entry. The
         // abort assignments come after the case, so they take priority.
         if (!waiting) begin
            tmo_cnt_reg <= '0;
         end else if (tmo_cnt_reg == TMO_W'(TIMEOUT_CYC - 1)) begin
            tmo_cnt_reg <= '0;
            timeout_reg <= 1'b1;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b1;
            pass        <= 1'b0;
            state_reg   <= S_DONE;
         end else begin
            tmo_cnt_reg <= tmo_cnt_reg + TMO_W'(1);
         end
`endif
      end
   end

endmodule

// File: tb/tb_mem_bist_master.sv
// tb_mem_bist_master
//   Directed testbench for mem_bist_master. A behavioural responder models
//   io_ctrl plus SRAM. It can corrupt reads, stretch ack after a drop, or
//   never acknowledge. Each scenario checks its result against hand-computed
//   constants.
//   Optional build macro: MEM_BIST_TIMEOUT_EN adds the ack-timeout scenario.
module tb_mem_bist_master;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [31:0] base_addr;
   logic [15:0] word_count;
   logic [31:0] seed;
   logic        busy, done, pass, timeout;
   logic [15:0] err_count;
   logic [31:0] first_err_addr;
   logic        mem_read, mem_write;
   logic        mem_ack;
   logic [31:0] mem_addr, mem_read_data, mem_write_data;

   int n_cmp = 0;
   int n_mis = 0;

   // responder state
   logic [31:0] mem [logic [31:0]];
   int          write_cnt, read_cnt, overlap_cnt, early_req_cnt;
   int          hold_extra, hold_cnt;
   bit          corrupt_en, never_ack;
   logic        req_prev;
   logic [31:0] rd_val;

   always #5 clk = ~clk;

   mem_bist_master #(
      .ADDR_STEP   (1),
      .CNT_W       (16),
      .TIMEOUT_CYC (16)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .start          (start),
      .base_addr      (base_addr),
      .word_count     (word_count),
      .seed           (seed),
      .busy           (busy),
      .done           (done),
      .pass           (pass),
      .err_count      (err_count),
      .first_err_addr (first_err_addr),
      .timeout        (timeout),
      .mem_read       (mem_read),
      .mem_write      (mem_write),
      .mem_ack        (mem_ack),
      .mem_addr       (mem_addr),
      .mem_read_data  (mem_read_data),
      .mem_write_data (mem_write_data)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
      end else begin
         $display("ok   %s: 0x%08h", tag, obs);
      end
   endtask

   // Responder: raises ack one cycle after a request and drops it one cycle
   // after the request falls, optionally stretched by hold_extra cycles.
   always @(posedge clk) begin
      #1;
      if (mem_read && mem_write) overlap_cnt++;
      // A new request must not appear while ack was still high at the edge.
      if ((mem_read || mem_write) && !req_prev && mem_ack) early_req_cnt++;
      req_prev = mem_read || mem_write;
      if (never_ack) begin
         mem_ack = 1'b0;
      end else if (mem_read || mem_write) begin
         if (!mem_ack) begin
            mem_ack  = 1'b1;
            hold_cnt = 0;
            if (mem_write) begin
               mem[mem_addr] = mem_write_data;
               write_cnt++;
            end else begin
               rd_val = mem.exists(mem_addr) ? mem[mem_addr] : 32'h0;
               if (corrupt_en && (mem_addr == 32'h102 || mem_addr == 32'h103))
                  rd_val = rd_val ^ 32'h1;
               mem_read_data = rd_val;
               read_cnt++;
            end
         end
      end else if (mem_ack) begin
         if (hold_cnt < hold_extra) hold_cnt++;
         else mem_ack = 1'b0;
      end
   end

   function automatic logic [31:0] mem_at(input logic [31:0] a);
      return mem.exists(a) ? mem[a] : 32'h0;
   endfunction

   task automatic clear_resp();
      mem.delete();
      write_cnt = 0; read_cnt = 0; overlap_cnt = 0; early_req_cnt = 0;
      hold_extra = 0; hold_cnt = 0; corrupt_en = 0; never_ack = 0;
      mem_ack = 1'b0; req_prev = 1'b0; mem_read_data = '0;
   endtask

   task automatic kick(input logic [31:0] b, input logic [15:0] n, input logic [31:0] s);
      @(negedge clk);
      base_addr = b; word_count = n; seed = s; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input int max_cyc);
      int k;
      k = 0;
      while (!done && k < max_cyc) begin
         @(negedge clk);
         k++;
      end
      check_eq("done_reached", {31'd0, done}, 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      reset = 1'b0; start = 1'b0; base_addr = '0; word_count = '0; seed = '0;
      clear_resp();
      repeat (3) @(negedge clk);

      // Reset state
      check_eq("rst_flags", {26'd0, busy, done, pass, timeout, mem_read, mem_write}, 32'd0);
      check_eq("rst_err_count", {16'd0, err_count}, 32'd0);
      check_eq("rst_first_err", first_err_addr, 32'd0);
      check_eq("rst_mem_addr", mem_addr, 32'd0);
      check_eq("rst_mem_wdata", mem_write_data, 32'd0);
      reset = 1'b1;
      @(negedge clk);

      // 1: ideal responder, 4 words; a start pulse mid-run must be ignored
      kick(32'h100, 16'd4, 32'hA5A5A5A5);
      check_eq("t1_busy", {31'd0, busy}, 32'd1);
      repeat (3) @(negedge clk);
      base_addr = 32'h0; word_count = 16'd0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(200);
      check_eq("t1_pass", {31'd0, pass}, 32'd1);
      check_eq("t1_busy_end", {31'd0, busy}, 32'd0);
      check_eq("t1_err_count", {16'd0, err_count}, 32'd0);
      check_eq("t1_first_err", first_err_addr, 32'd0);
      check_eq("t1_writes", write_cnt, 32'd4);
      check_eq("t1_reads", read_cnt, 32'd4);
      check_eq("t1_mem100", mem_at(32'h100), 32'hA5A5A4A5);
      check_eq("t1_mem101", mem_at(32'h101), 32'hA5A5A4A4);
      check_eq("t1_mem102", mem_at(32'h102), 32'hA5A5A4A7);
      check_eq("t1_mem103", mem_at(32'h103), 32'hA5A5A4A6);
      check_eq("t1_overlap", overlap_cnt, 32'd0);

      // 2: reads at 0x102 and 0x103 corrupted
      clear_resp();
      corrupt_en = 1;
      kick(32'h100, 16'd4, 32'hA5A5A5A5);
      wait_done(200);
      check_eq("t2_err_count", {16'd0, err_count}, 32'd2);
      check_eq("t2_first_err", first_err_addr, 32'h102);
      check_eq("t2_pass", {31'd0, pass}, 32'd0);
      check_eq("t2_timeout", {31'd0, timeout}, 32'd0);

      // 3: zero-length test finishes at once with no bus activity
      clear_resp();
      kick(32'h500, 16'd0, 32'h1);
      check_eq("t3_done", {31'd0, done}, 32'd1);
      check_eq("t3_pass", {31'd0, pass}, 32'd1);
      check_eq("t3_err_count", {16'd0, err_count}, 32'd0);
      repeat (4) @(negedge clk);
      check_eq("t3_bus_idle", write_cnt + read_cnt, 32'd0);

      // 4: ack held 3 extra cycles, range wraps past 0xFFFFFFFF
      clear_resp();
      hold_extra = 3;
      kick(32'hFFFFFFFE, 16'd4, 32'h12345678);
      wait_done(300);
      check_eq("t4_pass", {31'd0, pass}, 32'd1);
      check_eq("t4_early_req", early_req_cnt, 32'd0);
      check_eq("t4_overlap", overlap_cnt, 32'd0);
      check_eq("t4_memFFFFFFFF", mem_at(32'hFFFFFFFF), 32'hEDCBA987);
      check_eq("t4_mem0", mem_at(32'h0), 32'h12345678);
      check_eq("t4_mem1", mem_at(32'h1), 32'h12345679);

      // 5: asynchronous reset during the write of word 2
      clear_resp();
      kick(32'h200, 16'd4, 32'hCAFEF00D);
      k = 0;
      while (!(mem_write && mem_addr == 32'h202) && k < 50) begin
         @(negedge clk);
         k++;
      end
      check_eq("t5_reached_word2", {31'd0, mem_write && mem_addr == 32'h202}, 32'd1);
      #2 reset = 1'b0;
      #1;
      check_eq("t5_rst_flags", {26'd0, busy, done, pass, timeout, mem_read, mem_write}, 32'd0);
      check_eq("t5_rst_mem_addr", mem_addr, 32'd0);
      repeat (2) @(negedge clk);
      clear_resp();
      reset = 1'b1;
      kick(32'h300, 16'd2, 32'h0F0F0F0F);
      wait_done(200);
      check_eq("t5_pass", {31'd0, pass}, 32'd1);
      check_eq("t5_writes", write_cnt, 32'd2);
      check_eq("t5_mem301", mem_at(32'h301), 32'h0F0F0C0E);

`ifdef MEM_BIST_TIMEOUT_EN
      // 6: responder never acknowledges; abort after 16 cycles in WR_REQ
      clear_resp();
      never_ack = 1;
      kick(32'h400, 16'd4, 32'h0);
      repeat (15) @(negedge clk);
      check_eq("t6_still_waiting", {30'd0, mem_write, done}, 32'd2);
      @(negedge clk);
      check_eq("t6_timeout", {31'd0, timeout}, 32'd1);
      check_eq("t6_done", {31'd0, done}, 32'd1);
      check_eq("t6_pass", {31'd0, pass}, 32'd0);
      check_eq("t6_mem_write", {31'd0, mem_write}, 32'd0);
      check_eq("t6_err_count", {16'd0, err_count}, 32'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
